alarm_latch: RTL and testbench
==============================

ALARM_LATCH -- requirements
Module: alarm_latch

Interface
REQ-001 SHALL have parameter N_CH, default 6, number of PS-control fault channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive high samples needed to qualify a fault (1..65535).
REQ-003 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_Fault  in  N_CH  per-channel PS-control fault request, active-high.
REQ-006 SHALL have port i_Mask  in  N_CH  per-channel mask; 1 blocks setting that channel's latch.
REQ-007 SHALL have port i_Ack  in  1  operator acknowledge/clear, sampled level.
REQ-008 SHALL have port i_External  in  1  external emergency request, active-high.
REQ-009 SHALL have ports i_Not_TUNE_OK_Delayed, i_I_AN_5A, i_I_AN_6A  in  1 each  anode-current threshold select and comparator inputs.
REQ-010 SHALL have port o_Latched  out  N_CH  latched fault per channel.
REQ-011 SHALL have port o_Not_Alarm  out  1  low while any o_Latched bit is set.
REQ-012 SHALL have port o_Emergency  out  1  registered emergency.
REQ-013 SHALL have port o_I_AN_HIGH  out  1  active-low anode-overcurrent alarm.
REQ-014 SHALL have ports o_First_Valid  out  1  and o_First_Fault  out  clog2(N_CH) (min 1)  first-fault record.

Function
REQ-015 Each channel SHALL run a debounce counter: increments while i_Fault[k] sampled 1, saturates at DEBOUNCE_CYCLES, clears to 0 on any sample of 0.
REQ-016 Channel k SHALL be qualified when its counter equals DEBOUNCE_CYCLES; o_Latched[k] sets on the edge of the DEBOUNCE_CYCLES-th consecutive high sample if i_Mask[k]=0.
REQ-017 o_Latched[k] SHALL hold until an edge with i_Ack=1 and channel k unqualified; ack with channel still qualified leaves the bit set.
REQ-018 Set SHALL take priority over clear on the same edge.
REQ-019 i_Mask SHALL gate setting only; masking an already latched channel SHALL NOT clear it.
REQ-020 o_Not_Alarm SHALL equal NOR of o_Latched, combinational from the latch register (no extra cycle).
REQ-021 Anode path: raw = i_Not_TUNE_OK_Delayed ? i_I_AN_5A : i_I_AN_6A; raw SHALL pass through the same debounce; o_I_AN_HIGH SHALL be 0 while qualified, 1 otherwise (non-latching).
REQ-022 o_Emergency SHALL be i_External through a two-flop synchroniser (2-cycle latency), non-latching, unaffected by i_Mask or i_Ack.
REQ-023 First-fault: when o_First_Valid=0 and one or more channels set, SHALL record the lowest set index and assert o_First_Valid on the same edge.
REQ-024 Record SHALL hold while o_First_Valid=1 regardless of later channels; SHALL clear (valid=0, index=0) on the edge that leaves all o_Latched bits clear.

Reset
REQ-025 On reset SHALL clear all counters, o_Latched=0, o_Not_Alarm=1, o_I_AN_HIGH=1, o_Emergency=0, synchroniser flops=0, o_First_Valid=0, o_First_Fault=0.
REQ-026 Reset mid-debounce or with latches set SHALL discard all state; a still-high input requires a full DEBOUNCE_CYCLES after reset release.

Configuration
REQ-027 Macro ALARM_FIRST_FAULT_EN defined: REQ-023/024 logic present.
REQ-028 ALARM_FIRST_FAULT_EN undefined: no first-fault registers; o_First_Valid and o_First_Fault tied 0; all other behaviour identical.

Structure
REQ-029 Package alarm_pkg SHALL hold default N_CH and DEBOUNCE_CYCLES constants and the debounce-counter width derivation.
REQ-030 Sub-module alarm_debounce (one input, qualified output, parameter DEBOUNCE_CYCLES) SHALL be instantiated N_CH+1 times (channels plus anode path).

Verification
REQ-031 DEBOUNCE_CYCLES=16: i_Fault[2] high 15 cycles then low -> o_Latched stays 0, o_Not_Alarm stays 1.
REQ-032 i_Fault[2] high 16 cycles -> o_Latched=6'b000100 after 16th edge, o_Not_Alarm=0, o_First_Fault=2, o_First_Valid=1; i_Ack while high -> unchanged; drop input, i_Ack 1 cycle -> all clear, o_First_Valid=0.
REQ-033 i_Fault[4] and i_Fault[1] rise same cycle -> both latch, o_First_Fault=1; later i_Fault[5] latches -> o_First_Fault stays 1.
REQ-034 i_Mask[3]=1, i_Fault[3] high 40 cycles -> o_Latched[3]=0; latch ch3 unmasked then set mask -> bit remains until ack.
REQ-035 i_Not_TUNE_OK_Delayed=1, i_I_AN_5A=1 16 cycles -> o_I_AN_HIGH=0; switch select to 0 with i_I_AN_6A=0 -> o_I_AN_HIGH=1 next edge; i_External pulse -> o_Emergency follows 2 cycles later.
REQ-036 Latch ch0 then assert reset 1 cycle with i_Fault[0] still high -> all outputs at reset values; ch0 relatches 16 edges after reset release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared defaults and width helpers for the alarm latch block.
package alarm_pkg;

  localparam int N_CH_DEFAULT            = 6;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic int idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Saturating run-length debounce; hit_o flags that the counter reaches
// DEBOUNCE_CYCLES on the coming edge, so users can act on that same edge.
module alarm_debounce
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic hit_o
);

  localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = '0;
    if (in_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_d == CNT_MAX);

endmodule

// File: rtl/alarm_latch.sv
// Debounced per-channel fault latch with ack, anode overcurrent and emergency
// paths. Define ALARM_FIRST_FAULT_EN to include the first-fault record.
module alarm_latch
  import alarm_pkg::*;
#(
  parameter int N_CH            = N_CH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            i_Fault,
  input  logic [N_CH-1:0]            i_Mask,
  input  logic                       i_Ack,
  input  logic                       i_External,
  input  logic                       i_Not_TUNE_OK_Delayed,
  input  logic                       i_I_AN_5A,
  input  logic                       i_I_AN_6A,
  output logic [N_CH-1:0]            o_Latched,
  output logic                       o_Not_Alarm,
  output logic                       o_Emergency,
  output logic                       o_I_AN_HIGH,
  output logic                       o_First_Valid,
  output logic [idx_width(N_CH)-1:0] o_First_Fault
);

  localparam int IW = idx_width(N_CH);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] set_vec;
  logic [N_CH-1:0] latched_q, latched_d;
  logic            an_raw, an_hit, an_high_q;
  logic [1:0]      sync_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    alarm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .in_i  (i_Fault[k]),
      .hit_o (hit[k])
    );
  end

  assign an_raw = i_Not_TUNE_OK_Delayed ? i_I_AN_5A : i_I_AN_6A;

  alarm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_an (
    .clk   (clk),
    .reset (reset),
    .in_i  (an_raw),
    .hit_o (an_hit)
  );

  // Set wins over ack; ack only clears channels that are not qualified.
  assign set_vec   = hit & ~i_Mask;
  assign latched_d = set_vec | (latched_q & ~({N_CH{i_Ack}} & ~hit));

  always_ff @(posedge clk) begin
    if (reset) begin
      latched_q <= '0;
      an_high_q <= 1'b1;
      sync_q    <= 2'b00;
    end else begin
      latched_q <= latched_d;
      an_high_q <= ~an_hit;
      sync_q    <= {sync_q[0], i_External};
    end
  end

  assign o_Latched   = latched_q;
  assign o_Not_Alarm = ~|latched_q;
  assign o_I_AN_HIGH = an_high_q;
  assign o_Emergency = sync_q[1];

`ifdef ALARM_FIRST_FAULT_EN
  logic          first_valid_q, first_valid_d;
  logic [IW-1:0] first_idx_q, first_idx_d;

  // While nothing is recorded, latched_d can only be non-zero through set_vec.
  always_comb begin
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    if (latched_d == '0) begin
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end else if (!first_valid_q) begin
      first_valid_d = 1'b1;
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (set_vec[k]) first_idx_d = IW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else begin
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
    end
  end

  assign o_First_Valid = first_valid_q;
  assign o_First_Fault = first_idx_q;
`else
  assign o_First_Valid = 1'b0;
  assign o_First_Fault = '0;
`endif

endmodule

// File: tb/tb_alarm_latch.sv
// Directed scenarios plus randomized stimulus against a run-length reference model.
module tb_alarm_latch;

  localparam int N_CH = 6;
  localparam int DC   = 16;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] i_Fault, i_Mask;
  logic            i_Ack, i_External, i_Not_TUNE_OK_Delayed, i_I_AN_5A, i_I_AN_6A;
  logic [N_CH-1:0] o_Latched;
  logic            o_Not_Alarm, o_Emergency, o_I_AN_HIGH, o_First_Valid;
  logic [IW-1:0]   o_First_Fault;

  alarm_latch #(.N_CH(N_CH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_Fault               (i_Fault),
    .i_Mask                (i_Mask),
    .i_Ack                 (i_Ack),
    .i_External            (i_External),
    .i_Not_TUNE_OK_Delayed (i_Not_TUNE_OK_Delayed),
    .i_I_AN_5A             (i_I_AN_5A),
    .i_I_AN_6A             (i_I_AN_6A),
    .o_Latched             (o_Latched),
    .o_Not_Alarm           (o_Not_Alarm),
    .o_Emergency           (o_Emergency),
    .o_I_AN_HIGH           (o_I_AN_HIGH),
    .o_First_Valid         (o_First_Valid),
    .o_First_Fault         (o_First_Fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: length of the current run of high samples per input.
  int              run[N_CH];
  int              run_an;
  bit [N_CH-1:0]   m_latched;
  bit              m_fv;
  int              m_ff;
  bit              m_an_high;
  bit              ext_hist[$];

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) run[k] = 0;
    run_an    = 0;
    m_latched = '0;
    m_fv      = 1'b0;
    m_ff      = 0;
    m_an_high = 1'b1;
    ext_hist.delete();
  endtask

  task automatic model_edge();
    int  lowest;
    bit  raw;
    if (reset) begin
      model_reset();
      return;
    end
    lowest = -1;
    for (int k = 0; k < N_CH; k++) begin
      run[k] = i_Fault[k] ? run[k] + 1 : 0;
      if (run[k] >= DC && !i_Mask[k]) begin
        m_latched[k] = 1'b1;
        if (lowest < 0) lowest = k;
      end else if (i_Ack && run[k] < DC) begin
        m_latched[k] = 1'b0;
      end
    end
    if (m_latched == '0) begin
      m_fv = 1'b0;
      m_ff = 0;
    end else if (!m_fv) begin
      m_fv = 1'b1;
      m_ff = lowest;
    end
    raw       = i_Not_TUNE_OK_Delayed ? i_I_AN_5A : i_I_AN_6A;
    run_an    = raw ? run_an + 1 : 0;
    m_an_high = !(run_an >= DC);
    ext_hist.push_front(i_External);
    if (ext_hist.size() > 2) void'(ext_hist.pop_back());
  endtask

  function automatic bit exp_fv();
`ifdef ALARM_FIRST_FAULT_EN
    return m_fv;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_ff();
`ifdef ALARM_FIRST_FAULT_EN
    return m_ff;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".latched"},   o_Latched,     m_latched);
    check({ctx, ".not_alarm"}, o_Not_Alarm,   (m_latched == '0));
    check({ctx, ".an_high"},   o_I_AN_HIGH,   m_an_high);
    check({ctx, ".emergency"}, o_Emergency,   (ext_hist.size() >= 2) ? ext_hist[1] : 1'b0);
    check({ctx, ".first_v"},   o_First_Valid, exp_fv());
    check({ctx, ".first_f"},   o_First_Fault, exp_ff());
  endtask

  // Model and DUT advance on the same edge; outputs are read on the falling edge.
  task automatic step(input string ctx, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(ctx);
    end
  endtask

  task automatic idle_clear();
    i_Fault = '0; i_Mask = '0; i_Ack = 1'b0; i_External = 1'b0;
    step("clr", 1);
    i_Ack = 1'b1;
    step("clr", 1);
    i_Ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_Fault = '0; i_Mask = '0; i_Ack = 1'b0; i_External = 1'b0;
    i_Not_TUNE_OK_Delayed = 1'b0; i_I_AN_5A = 1'b0; i_I_AN_6A = 1'b0;
    model_reset();
    @(negedge clk);
    step("rst", 2);
    check("rst.latched",   o_Latched, 0);
    check("rst.not_alarm", o_Not_Alarm, 1);
    check("rst.an_high",   o_I_AN_HIGH, 1);
    check("rst.emergency", o_Emergency, 0);
    reset = 1'b0;

    // 15 high samples never qualify.
    i_Fault[2] = 1'b1;
    step("d15", 15);
    i_Fault[2] = 1'b0;
    step("d15", 1);
    check("d15.latched", o_Latched, 0);

    // 16 high samples latch channel 2; ack while high is ignored.
    i_Fault[2] = 1'b1;
    step("d16", 16);
    check("d16.latched",   o_Latched, 6'b000100);
    check("d16.not_alarm", o_Not_Alarm, 0);
    check("d16.first_f",   o_First_Fault, exp_ff());
    i_Ack = 1'b1;
    step("ackhi", 3);
    check("ackhi.latched", o_Latched, 6'b000100);
    i_Ack = 1'b0; i_Fault[2] = 1'b0;
    step("drop", 1);
    i_Ack = 1'b1;
    step("ack", 1);
    i_Ack = 1'b0;
    check("ack.latched", o_Latched, 0);
    check("ack.first_v", o_First_Valid, 0);

    // Simultaneous channels 4 and 1, then channel 5 later.
    i_Fault[4] = 1'b1; i_Fault[1] = 1'b1;
    step("dual", 16);
    check("dual.latched", o_Latched, 6'b010010);
    i_Fault[5] = 1'b1;
    step("late", 16);
    check("late.latched", o_Latched, 6'b110010);
    check("late.first_f", o_First_Fault, exp_ff());
    idle_clear();

    // Mask blocks setting but never clears an existing latch.
    i_Mask[3] = 1'b1; i_Fault[3] = 1'b1;
    step("mask", 40);
    check("mask.latched", o_Latched, 0);
    i_Fault[3] = 1'b0;
    step("mask", 1);
    i_Mask[3] = 1'b0; i_Fault[3] = 1'b1;
    step("unm", 16);
    check("unm.latched", o_Latched, 6'b001000);
    i_Mask[3] = 1'b1; i_Fault[3] = 1'b0;
    step("remask", 3);
    check("remask.latched", o_Latched, 6'b001000);
    i_Ack = 1'b1;
    step("remask", 1);
    i_Ack = 1'b0; i_Mask = '0;
    check("remask.cleared", o_Latched, 0);

    // Anode threshold select and external emergency path.
    i_Not_TUNE_OK_Delayed = 1'b1; i_I_AN_5A = 1'b1;
    step("an", 16);
    check("an.high", o_I_AN_HIGH, 0);
    i_Not_TUNE_OK_Delayed = 1'b0; i_I_AN_6A = 1'b0;
    step("an", 1);
    check("an.release", o_I_AN_HIGH, 1);
    i_I_AN_5A = 1'b0;
    i_External = 1'b1;
    step("ext", 1);
    check("ext.lat1", o_Emergency, 0);
    i_External = 1'b0;
    step("ext", 1);
    check("ext.lat2", o_Emergency, 1);
    step("ext", 1);
    check("ext.fall", o_Emergency, 0);

    // Reset with channel 0 latched and still high.
    i_Fault[0] = 1'b1;
    step("r0", 16);
    check("r0.latched", o_Latched, 6'b000001);
    reset = 1'b1;
    step("r0rst", 1);
    reset = 1'b0;
    check("r0rst.latched",   o_Latched, 0);
    check("r0rst.not_alarm", o_Not_Alarm, 1);
    step("r0re", 15);
    check("r0re.early", o_Latched, 0);
    step("r0re", 1);
    check("r0re.relatch", o_Latched, 6'b000001);
    idle_clear();

    // Randomized soak: slowly toggling faults so runs reach the threshold.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(23) == 0) i_Fault[k] = ~i_Fault[k];
        if ($urandom_range(63) == 0) i_Mask[k]  = ~i_Mask[k];
      end
      i_Ack      = ($urandom_range(7) == 0);
      i_External = ($urandom_range(3) == 0);
      if ($urandom_range(39) == 0) i_Not_TUNE_OK_Delayed = ~i_Not_TUNE_OK_Delayed;
      if ($urandom_range(19) == 0) i_I_AN_5A = ~i_I_AN_5A;
      if ($urandom_range(19) == 0) i_I_AN_6A = ~i_I_AN_6A;
      reset = ($urandom_range(399) == 0);
      step("rnd", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
